pcie_rq_arbiter: RTL and testbench

Round-robin arbiter that shares the single-outstanding read and write request ports of the AXI request controllers between `NUM_REQ` internal requesters, such as descriptor fetch, Ib SRAM fill and Ob SRAM drain. It grants one requester at a time and routes the request to the read or write controller. It holds the request stable until the controller completes, captures the response and error, and returns them to the granted requester. It sits between the DMA/crypto sequencing logic and the read/write request controllers inside the PCIe sub-controller top.

---
 rtl/pcie_rq_pkg.sv | 16 +
 rtl/pcie_rq_arbiter_rr_pick.sv | 29 ++
 rtl/pcie_rq_arbiter.sv | 129 ++++++++++++
 tb/tb_pcie_rq_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_rq_pkg.sv
// Shared types and constants for the PCIe request arbiter.
package pcie_rq_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StWerr = 2'd2,
    StDone = 2'd3
  } RqArbSt_t;

  localparam int unsigned RQ_NUM_REQ_DEF = 4;
  localparam int unsigned RQ_ID_W        = $clog2(RQ_NUM_REQ_DEF);

  localparam logic RQ_OKAY = 1'b0;

endpackage

// File: rtl/pcie_rq_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester after `last`, wrapping.
module rr_pick
  import pcie_rq_pkg::*;
#(
  parameter int unsigned NUM_REQ = RQ_NUM_REQ_DEF,
  parameter int unsigned IdW     = RQ_ID_W
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IdW-1:0]     last,
  output logic [IdW-1:0]     gnt_id,
  output logic               any
);

  logic [IdW-1:0] idx;

  always_comb begin
    gnt_id = last;
    any    = 1'b0;
    idx    = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = IdW'((32'(last) + i) % NUM_REQ);
      if (!any && req[idx]) begin
        gnt_id = idx;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pcie_rq_arbiter.sv
// Round-robin arbiter sharing the single-outstanding read/write request ports
// between NUM_REQ requesters; all outputs are registered.
module pcie_rq_arbiter
  import pcie_rq_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned TMO_W   = 12
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         ReqValid,
  input  logic [NUM_REQ-1:0]         ReqWr,
  input  logic [NUM_REQ*ADDR_W-1:0]  ReqAddr,
  input  logic [NUM_REQ*DATA_W-1:0]  ReqData,
  output logic [NUM_REQ-1:0]         ReqDone,
  output logic                       ReqErr,
  output logic [DATA_W-1:0]          RspData,
  output logic                       RdRqValid,
  output logic [ADDR_W-1:0]          RdRqAddr,
  input  logic [DATA_W-1:0]          RdRqData,
  input  logic                       RdRqReady,
  input  logic                       RdRqErr,
  output logic                       WrRqValid,
  output logic [ADDR_W-1:0]          WrRqAddr,
  output logic [DATA_W-1:0]          WrRqData,
  input  logic                       WrRqReady,
  input  logic                       WrRqErr,
  output logic [$clog2(NUM_REQ)-1:0] GrantId,
  output logic                       Busy,
  output logic                       TmoErr
);

  localparam int unsigned IdW = $clog2(NUM_REQ);

  RqArbSt_t       state_q, state_d;
  logic [IdW-1:0] last_q;
  logic           wr_q;
  logic [TMO_W-1:0] tmo_q;
  logic [IdW-1:0] pick;
  logic           any;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IdW     (IdW)
  ) u_rr_pick (
    .req    (ReqValid),
    .last   (last_q),
    .gnt_id (pick),
    .any    (any)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (any) state_d = StBusy;
      StBusy: begin
        if (wr_q && WrRqReady)        state_d = StWerr;
        else if (!wr_q && RdRqReady)  state_d = StDone;
      end
      StWerr:  state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      last_q    <= IdW'(NUM_REQ - 1);
      wr_q      <= 1'b0;
      tmo_q     <= '0;
      ReqDone   <= '0;
      ReqErr    <= 1'b0;
      RspData   <= '0;
      RdRqValid <= 1'b0;
      RdRqAddr  <= '0;
      WrRqValid <= 1'b0;
      WrRqAddr  <= '0;
      WrRqData  <= '0;
      GrantId   <= '0;
      Busy      <= 1'b0;
      TmoErr    <= 1'b0;
    end else begin
      state_q <= state_d;
      Busy    <= (state_d != StIdle);
      ReqDone <= '0;
      ReqErr  <= RQ_OKAY;
      unique case (state_q)
        StIdle: begin
          if (any) begin
            GrantId <= pick;
            last_q  <= pick;
            wr_q    <= ReqWr[pick];
            tmo_q   <= '0;
            if (ReqWr[pick]) begin
              WrRqValid <= 1'b1;
              WrRqAddr  <= ReqAddr[int'(pick)*ADDR_W +: ADDR_W];
              WrRqData  <= ReqData[int'(pick)*DATA_W +: DATA_W];
            end else begin
              RdRqValid <= 1'b1;
              RdRqAddr  <= ReqAddr[int'(pick)*ADDR_W +: ADDR_W];
            end
          end
        end
        StBusy: begin
          // Watchdog only flags; the controller may still be mid-burst.
          if (&tmo_q) TmoErr <= 1'b1;
          else        tmo_q  <= tmo_q + 1'b1;
          if (!wr_q && RdRqReady) begin
            RdRqValid <= 1'b0;
            RspData   <= RdRqData;
            ReqErr    <= RdRqErr;
            ReqDone   <= NUM_REQ'(1) << GrantId;
          end
          if (wr_q && WrRqReady) WrRqValid <= 1'b0;
        end
        StWerr: begin
          ReqErr  <= WrRqErr;
          ReqDone <= NUM_REQ'(1) << GrantId;
        end
        StDone:  ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pcie_rq_arbiter.sv
// Directed self-checking bench for pcie_rq_arbiter (NUM_REQ=4, 64b addr, 128b data).
module tb_pcie_rq_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 64;
  localparam int unsigned DW = 128;

  logic            clk, rst_n;
  logic [N-1:0]    ReqValid, ReqWr, ReqDone;
  logic [N*AW-1:0] ReqAddr;
  logic [N*DW-1:0] ReqData;
  logic            ReqErr, RdRqValid, RdRqReady, RdRqErr;
  logic            WrRqValid, WrRqReady, WrRqErr, Busy, TmoErr;
  logic [DW-1:0]   RspData, RdRqData, WrRqData;
  logic [AW-1:0]   RdRqAddr, WrRqAddr;
  logic [1:0]      GrantId;

  pcie_rq_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TMO_W(12)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ReqValid  (ReqValid),
    .ReqWr     (ReqWr),
    .ReqAddr   (ReqAddr),
    .ReqData   (ReqData),
    .ReqDone   (ReqDone),
    .ReqErr    (ReqErr),
    .RspData   (RspData),
    .RdRqValid (RdRqValid),
    .RdRqAddr  (RdRqAddr),
    .RdRqData  (RdRqData),
    .RdRqReady (RdRqReady),
    .RdRqErr   (RdRqErr),
    .WrRqValid (WrRqValid),
    .WrRqAddr  (WrRqAddr),
    .WrRqData  (WrRqData),
    .WrRqReady (WrRqReady),
    .WrRqErr   (WrRqErr),
    .GrantId   (GrantId),
    .Busy      (Busy),
    .TmoErr    (TmoErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Bus monitors, sampled on the falling edge.
  int   both_hi = 0;
  int   issues  = 0;
  logic any_prev = 1'b0;
  always @(negedge clk) begin
    if (RdRqValid && WrRqValid) both_hi++;
    if ((RdRqValid || WrRqValid) && !any_prev) issues++;
    any_prev = RdRqValid || WrRqValid;
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ReqValid = '0; ReqWr = '0; ReqAddr = '0; ReqData = '0;
    RdRqData = '0; RdRqReady = 0; RdRqErr = 0; WrRqReady = 0; WrRqErr = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Wait for an issue, record the grant, answer after `lat` cycles, wait for ReqDone.
  task automatic serve(input int lat, output logic [1:0] gid);
    int n;
    logic [3:0] exp_done;
    n = 0;
    while (!(RdRqValid || WrRqValid) && n < 50) begin tick(); n++; end
    check_eq("issue_seen", 1'(n < 50), 1'b1);
    gid = GrantId;
    exp_done = 4'b0001 << gid;
    repeat (lat) tick();
    if (RdRqValid) RdRqReady = 1'b1;
    else           WrRqReady = 1'b1;
    tick();
    RdRqReady = 1'b0;
    WrRqReady = 1'b0;
    n = 0;
    while (ReqDone == '0 && n < 10) begin tick(); n++; end
    check_eq("serve_done", ReqDone, exp_done);
    tick();
  endtask

  initial begin
    logic [1:0] gid;
    int both0, iss0;
    idle_inputs();
    do_reset();

    // Reset state
    check_eq("rst_busy", Busy, 0);
    check_eq("rst_rdv", RdRqValid, 0);
    check_eq("rst_wrv", WrRqValid, 0);
    check_eq("rst_done", ReqDone, 0);
    check_eq("rst_grant", GrantId, 0);
    check_eq("rst_rsp", RspData, 0);

    // Single read from requester 2: ReqDone 7 cycles after ReqValid.
    ReqValid = 4'b0100;
    ReqAddr[2*AW +: AW] = 64'h1000;
    tick();
    check_eq("rd_valid", RdRqValid, 1);
    check_eq("rd_addr", RdRqAddr, 64'h1000);
    check_eq("rd_grant", GrantId, 2);
    check_eq("rd_busy", Busy, 1);
    repeat (5) tick();
    check_eq("rd_no_early_done", ReqDone, 0);
    RdRqReady = 1'b1;
    RdRqData  = {16{8'hA5}};
    tick();
    RdRqReady = 1'b0;
    check_eq("rd_done", ReqDone, 4'b0100);
    check_eq("rd_rsp", RspData, {16{8'hA5}});
    check_eq("rd_err", ReqErr, 0);
    check_eq("rd_valid_drop", RdRqValid, 0);
    ReqValid = '0;
    tick();
    check_eq("rd_idle", Busy, 0);
    check_eq("rd_done_pulse", ReqDone, 0);

    // Write from requester 1 with a late error.
    ReqValid = 4'b0010;
    ReqWr    = 4'b0010;
    ReqAddr[1*AW +: AW] = 64'h2000;
    ReqData[1*DW +: DW] = 128'h1234;
    tick();
    check_eq("wr_valid", WrRqValid, 1);
    check_eq("wr_rd_quiet", RdRqValid, 0);
    check_eq("wr_addr", WrRqAddr, 64'h2000);
    check_eq("wr_data", WrRqData, 128'h1234);
    check_eq("wr_grant", GrantId, 1);
    WrRqReady = 1'b1;
    tick();
    WrRqReady = 1'b0;
    WrRqErr   = 1'b1;
    check_eq("wr_valid_drop", WrRqValid, 0);
    check_eq("wr_not_yet", ReqDone, 0);
    tick();
    WrRqErr = 1'b0;
    check_eq("wr_done", ReqDone, 4'b0010);
    check_eq("wr_err", ReqErr, 1);
    check_eq("wr_rsp_hold", RspData, {16{8'hA5}});
    ReqValid = '0;
    ReqWr    = '0;
    tick();

    // All four held valid after reset: grants 0,1,2,3,0.
    do_reset();
    both0 = both_hi;
    iss0  = issues;
    ReqValid = 4'b1111;
    ReqWr    = 4'b1010;
    serve(1, gid); check_eq("rr_0", gid, 0);
    serve(0, gid); check_eq("rr_1", gid, 1);
    serve(2, gid); check_eq("rr_2", gid, 2);
    serve(1, gid); check_eq("rr_3", gid, 3);
    serve(0, gid); check_eq("rr_4", gid, 0);
    ReqValid = '0;
    ReqWr    = '0;
    tick();
    tick();
    check_eq("rr_exclusive", both_hi - both0, 0);
    check_eq("rr_issue_count", issues - iss0, 5);

    // Requester 3 write vs pending requester 0 that withdraws; last grant was 0.
    ReqValid = 4'b1001;
    ReqWr    = 4'b1000;
    ReqAddr[3*AW +: AW] = 64'h3000;
    ReqData[3*DW +: DW] = 128'hBEEF;
    tick();
    check_eq("hold_grant", GrantId, 3);
    ReqAddr[3*AW +: AW] = 64'hDEAD0;
    ReqData[3*DW +: DW] = 128'hFFFF;
    ReqValid = 4'b1000;
    tick();
    tick();
    check_eq("hold_addr", WrRqAddr, 64'h3000);
    check_eq("hold_data", WrRqData, 128'hBEEF);
    WrRqReady = 1'b1;
    tick();
    WrRqReady = 1'b0;
    tick();
    check_eq("hold_done", ReqDone, 4'b1000);
    ReqValid = '0;
    ReqWr    = '0;
    repeat (3) tick();
    check_eq("withdraw_idle", Busy, 0);
    check_eq("withdraw_grant", GrantId, 3);

    // Watchdog: expires on the 4096th BUSY cycle, transaction survives.
    ReqValid = 4'b0100;
    ReqAddr[2*AW +: AW] = 64'h4000;
    tick();
    repeat (4095) tick();
    check_eq("tmo_not_yet", TmoErr, 0);
    tick();
    check_eq("tmo_set", TmoErr, 1);
    check_eq("tmo_busy", Busy, 1);
    check_eq("tmo_rdv", RdRqValid, 1);
    RdRqReady = 1'b1;
    RdRqData  = 128'h55;
    tick();
    RdRqReady = 1'b0;
    check_eq("tmo_done", ReqDone, 4'b0100);
    check_eq("tmo_rsp", RspData, 128'h55);
    ReqValid = '0;
    tick();
    check_eq("tmo_sticky", TmoErr, 1);

    // Asynchronous reset in BUSY.
    ReqValid = 4'b0110;
    tick();
    check_eq("ar_busy", Busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("ar_rdv", RdRqValid, 0);
    check_eq("ar_addr", RdRqAddr, 0);
    check_eq("ar_busy0", Busy, 0);
    check_eq("ar_tmo", TmoErr, 0);
    check_eq("ar_rsp", RspData, 0);
    check_eq("ar_grant0", GrantId, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("ar_first_grant", GrantId, 1);
    check_eq("ar_no_done", ReqDone, 0);
    check_eq("ar_reissue", RdRqValid, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
